// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared state encoding, width defaults and channel ids for fir_sched
package fir_sched_pkg;
  typedef enum logic [2:0] {IDLE, WR_L, WR_R, CLR_L, WAIT_L, CLR_R, WAIT_R, OUT} state_t;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 16;
  localparam logic CHAN_L = 1'b0;
  localparam logic CHAN_R = 1'b1;
endpackage

// File: rtl/fir_sched.sv
// fir_sched: shares one fir_filter MAC between left/right channels per stereo sample
// FIR_SCHED_BYPASS_EN adds a bypass input that skips filtering and returns raw samples.
module fir_sched
  import fir_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAST_ADDR = 127,
  parameter int DONE_GUARD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  output logic              sample_ready,
  output logic              buf_wr_en,
  output logic              buf_wr_chan,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              fir_reset,
  output logic              fir_chan,
  output logic [ADDR_W-1:0] fir_start_addr,
  output logic [ADDR_W-1:0] fir_last_addr,
  input  logic              fir_done,
  input  logic [DATA_W-1:0] fir_result,
`ifdef FIR_SCHED_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              busy,
  output logic              overrun
);
  localparam int GW = DONE_GUARD > 1 ? $clog2(DONE_GUARD + 1) : 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] wptr;
  logic [GW-1:0] guard;
  logic [DATA_W-1:0] in_l, in_r;
  logic skip, hit;
`ifdef FIR_SCHED_BYPASS_EN
  logic byp_r;
  assign skip = byp_r;
`else
  assign skip = 1'b0;
`endif
  assign hit = fir_done && guard == '0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = sample_valid ? WR_L : IDLE;
      WR_L:    state_n = WR_R;
      WR_R:    state_n = skip ? OUT : CLR_L;
      CLR_L:   state_n = WAIT_L;
      WAIT_L:  state_n = hit ? CLR_R : WAIT_L;
      CLR_R:   state_n = WAIT_R;
      WAIT_R:  state_n = hit ? OUT : WAIT_R;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign sample_ready   = state == IDLE;
  assign busy           = state != IDLE;
  assign buf_wr_en      = state == WR_L || state == WR_R;
  assign buf_wr_chan    = state == WR_R ? CHAN_R : CHAN_L;
  assign buf_wr_addr    = wptr;
  assign buf_wr_data    = state == WR_R ? in_r : in_l;
  assign fir_reset      = !(state == WAIT_L || state == WAIT_R);
  assign fir_chan       = (state == CLR_R || state == WAIT_R) ? CHAN_R : CHAN_L;
  assign fir_start_addr = wptr;
  assign fir_last_addr  = ADDR_W'(LAST_ADDR);
  assign out_valid      = state == OUT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      guard     <= '0;
      in_l      <= '0;
      in_r      <= '0;
      out_left  <= '0;
      out_right <= '0;
      overrun   <= 1'b0;
`ifdef FIR_SCHED_BYPASS_EN
      byp_r     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && sample_valid) begin
        in_l <= sample_left;
        in_r <= sample_right;
`ifdef FIR_SCHED_BYPASS_EN
        byp_r <= bypass;
`endif
      end
      if (state != IDLE && sample_valid) overrun <= 1'b1;
      // wptr advancing here leaves it pointing at the oldest sample for the filter run
      if (state == WR_R) wptr <= wptr == ADDR_W'(LAST_ADDR) ? '0 : wptr + ADDR_W'(1);
      if (state == CLR_L || state == CLR_R) guard <= GW'(DONE_GUARD);
      else if (guard != '0) guard <= guard - GW'(1);
      if (state == WAIT_L && hit) out_left <= fir_result;
      if (state == WAIT_R && hit) out_right <= fir_result;
      if (state == WR_R && skip) begin
        out_left  <= in_l;
        out_right <= in_r;
      end
    end
  end
endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: randomized scoreboard bench for fir_sched with a behavioural filter model
module tb_fir_sched;
  localparam int AW = 7, DW = 16, LAST = 127, G = 2;
  logic clk = 0, reset = 1, sample_valid = 0;
  logic [DW-1:0] sample_left = 0, sample_right = 0;
  logic sample_ready, buf_wr_en, buf_wr_chan, fir_reset, fir_chan, out_valid, busy, overrun;
  logic [AW-1:0] buf_wr_addr, fir_start_addr, fir_last_addr;
  logic [DW-1:0] buf_wr_data, out_left, out_right;
  logic fir_done = 0;
  logic [DW-1:0] fir_result = 0;
`ifdef FIR_SCHED_BYPASS_EN
  logic bypass = 0;
`endif
  always #5 clk = ~clk;

  fir_sched dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_left(sample_left),
    .sample_right(sample_right), .sample_ready(sample_ready), .buf_wr_en(buf_wr_en),
    .buf_wr_chan(buf_wr_chan), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .fir_reset(fir_reset), .fir_chan(fir_chan), .fir_start_addr(fir_start_addr),
    .fir_last_addr(fir_last_addr), .fir_done(fir_done), .fir_result(fir_result),
`ifdef FIR_SCHED_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid), .out_left(out_left), .out_right(out_right),
    .busy(busy), .overrun(overrun)
  );

  typedef struct packed {logic chan; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t wq[$];
  logic [2*DW-1:0] oq[$];
  int total = 0, bad = 0, cyc = 0, outs = 0, out_cyc = 0, acc = 0, mwp = 0;
  logic [AW-1:0] exp_start = 0;
  logic [DW-1:0] base_l = 0, base_r = 0;
  int dly = 0, k = 0, low_cnt = 0;
  bit early = 0;
  wr_t w;
  logic [2*DW-1:0] o;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // filter model: result counts up from base once done is raised after dly cycles out of reset
  always @(negedge clk) begin
    if (fir_reset) begin
      k = 0;
      fir_done = early;
      fir_result = 16'hBAD0;
    end else begin
      fir_done = early || k >= dly;
      fir_result = k >= dly ? (fir_chan ? base_r : base_l) + 16'(k - dly) : 16'hDEAD;
      k++;
    end
  end

  always @(negedge clk) if (!reset) begin
    if (!fir_reset) low_cnt++;
    if (buf_wr_en) begin
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        w = wq.pop_front();
        chk("wr_chan", 32'(buf_wr_chan), 32'(w.chan));
        chk("wr_addr", 32'(buf_wr_addr), 32'(w.addr));
        chk("wr_data", 32'(buf_wr_data), 32'(w.data));
      end
    end
    if (!fir_reset) chk("start_addr", 32'(fir_start_addr), 32'(exp_start));
    if (out_valid) begin
      outs++;
      out_cyc = cyc;
      if (oq.size() == 0) flag("unexpected_out_valid");
      else begin
        o = oq.pop_front();
        chk("out_left", 32'(out_left), 32'(o[2*DW-1:DW]));
        chk("out_right", 32'(out_right), 32'(o[DW-1:0]));
      end
    end
  end

  task automatic send(logic [DW-1:0] l, r, bl, br, int d, bit byp);
    int n = 0;
    int eff;
    while (!sample_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) flag("ready_timeout");
    base_l = bl;
    base_r = br;
    dly = d;
    sample_left = l;
    sample_right = r;
    sample_valid = 1;
`ifdef FIR_SCHED_BYPASS_EN
    bypass = byp;
`endif
    wq.push_back({1'b0, AW'(mwp), l});
    wq.push_back({1'b1, AW'(mwp), r});
    mwp = mwp == LAST ? 0 : mwp + 1;
    exp_start = AW'(mwp);
    eff = (d > G ? d : G) - d;
    oq.push_back(byp ? {l, r} : {bl + 16'(eff), br + 16'(eff)});
    acc = cyc;
    low_cnt = 0;
    @(negedge clk);
    sample_valid = 0;
`ifdef FIR_SCHED_BYPASS_EN
    bypass = 0;
`endif
  endtask

  task automatic wait_out();
    int o0 = outs;
    int n = 0;
    while (outs == o0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (outs == o0) flag("out_valid_timeout");
  endtask

  task automatic wait_wait(bit ch);
    int n = 0;
    while (!(!fir_reset && fir_chan == ch) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (fir_reset) flag("wait_state_timeout");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_ready", 32'(sample_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fir_reset", 32'(fir_reset), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_wr_en", 32'(buf_wr_en), 0);
    chk("rst_fir_chan", 32'(fir_chan), 0);
    chk("rst_out_left", 32'(out_left), 0);
    chk("rst_out_right", 32'(out_right), 0);
    chk("last_addr", 32'(fir_last_addr), LAST);

    send(16'h1000, 16'hF000, 16'h0123, 16'h0456, 5, 0);
    wait_out();
    chk("idle_after_out", 32'(busy), 0);
    chk("no_overrun", 32'(overrun), 0);

    for (int i = 1; i < 128; i++) begin
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 6), 0);
      wait_out();
    end
    chk("wrapped_ptr", 32'(fir_start_addr), 0);
    send(16'($urandom), 16'($urandom), 16'h2000, 16'h3000, 3, 0);
    wait_out();

    early = 1;
    send(16'h0A0A, 16'h0B0B, 16'h4000, 16'h5000, 0, 0);
    wait_out();
    early = 0;

    send(16'h1111, 16'h2222, 16'h6000, 16'h7000, 8, 0);
    wait_wait(0);
    sample_left = 16'hAAAA;
    sample_right = 16'h5555;
    sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    chk("overrun_set", 32'(overrun), 1);
    wait_out();
    send(16'h3333, 16'h4444, 16'h0100, 16'h0200, 2, 0);
    wait_out();
    chk("overrun_sticky", 32'(overrun), 1);

    send(16'h5555, 16'h6666, 16'h0300, 16'h0400, 20, 0);
    wait_wait(1);
    #2 reset = 1;
    #1;
    chk("abort_fir_reset", 32'(fir_reset), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_overrun", 32'(overrun), 0);
    wq.delete();
    oq.delete();
    mwp = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    send(16'h7777, 16'h8888, 16'h0500, 16'h0600, 1, 0);
    wait_out();

`ifdef FIR_SCHED_BYPASS_EN
    send(16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0, 1);
    wait_out();
    chk("bypass_latency", 32'(out_cyc - acc), 3);
    chk("bypass_fir_reset_low_cycles", 32'(low_cnt), 0);
    send(16'h0001, 16'h0002, 16'h0700, 16'h0800, 4, 0);
    wait_out();
`endif
    repeat (5) @(negedge clk);
    if (wq.size() != 0 || oq.size() != 0) flag("scoreboard_not_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_sched.md
Name: fir_sched

Overview:
- Per-sample controller that time-multiplexes one shared fir_filter MAC datapath between the left and right audio channels.
- On each incoming stereo sample pair it:
  - writes both samples into per-channel circular history buffers;
  - runs the filter on the left channel, then on the right;
  - captures both results and presents them as one output pair.
- Sits between the codec sample interface and the fir_filter/buffer RAM instances.

Parameters:
- ADDR_W, 7, history/kernel address width.
- DATA_W, 16, sample and result width.
- LAST_ADDR, 127, last valid buffer/kernel address; history length = LAST_ADDR+1.
- DONE_GUARD, 2, cycles fir_done is ignored after fir_reset deasserts (covers the filter's enable pipeline).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: new stereo pair present.
- sample_left  in  DATA_W  left input sample.
- sample_right  in  DATA_W  right input sample.
- sample_ready  out  1  high when in IDLE (pair will be accepted).
- buf_wr_en  out  1  history RAM write strobe.
- buf_wr_chan  out  1  0 = left RAM, 1 = right RAM (write side).
- buf_wr_addr  out  ADDR_W  write address (= wptr).
- buf_wr_data  out  DATA_W  write data.
- fir_reset  out  1  drives filter reset; high = filter held cleared.
- fir_chan  out  1  selects which channel's history RAM feeds the filter read port.
- fir_start_addr  out  ADDR_W  oldest-sample address given to the filter.
- fir_last_addr  out  ADDR_W  constant LAST_ADDR.
- fir_done  in  1  filter done.
- fir_result  in  DATA_W  filter result.
- out_valid  out  1  one-cycle strobe: output pair valid.
- out_left  out  DATA_W  filtered left result, held until next out_valid.
- out_right  out  DATA_W  filtered right result, held until next out_valid.
- busy  out  1  high whenever not in IDLE.
- overrun  out  1  sticky: a sample_valid arrived while busy.

Behaviour:
- Reset (async): state=IDLE, wptr=0, fir_reset=1, guard count=0.
  - All other outputs 0: out_left, out_right, out_valid, overrun, buf_wr_en, fir_chan.
  - Reset mid-operation aborts the run immediately; no out_valid is issued.
- States: IDLE, WR_L, WR_R, CLR_L, WAIT_L, CLR_R, WAIT_R, OUT.
- IDLE: sample_ready=1. On sample_valid, both samples are registered; next state is WR_L.
- WR_L: buf_wr_en=1, chan 0, addr=wptr, data=left; next state WR_R.
- WR_R: buf_wr_en=1, chan 1, addr=wptr, data=right.
  - wptr advances at the end of WR_R: wptr == LAST_ADDR wraps to 0, else +1.
  - Next state CLR_L.
- Start address: fir_start_addr = wptr after the advance, i.e. the oldest sample. Stable from CLR_L through OUT.
- CLR_L: fir_reset=1, fir_chan=0; guard loaded with DONE_GUARD; next state WAIT_L.
- WAIT_L: fir_reset=0, fir_chan=0.
  - Guard decrements to 0; fir_done is ignored while guard≠0.
  - When fir_done=1 with guard=0: fir_result is latched into out_left; next state CLR_R.
- CLR_R and WAIT_R: same as CLR_L/WAIT_L with fir_chan=1; the result is latched into out_right; next state OUT.
- OUT: out_valid=1 for exactly one cycle; next state IDLE.
  - out_left and out_right both update before out_valid and remain stable afterwards.
- fir_reset is 1 in every state except WAIT_L and WAIT_R.
- No timeout: WAIT_* waits indefinitely for fir_done.
- Overrun:
  - sample_valid while not in IDLE is dropped and sets overrun; overrun is cleared only by reset.
  - sample_valid in IDLE is accepted normally.
  - sample_valid during OUT is dropped; IDLE follows on the next cycle.
- Latency:
  - Accept edge to first write: 1 cycle.
  - Accept to out_valid = 5 + 2·DONE_GUARD + filter run time (both channels).

Optional Feature:
- Macro: FIR_SCHED_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled on accept.
  - When bypass=1: buffers are still written and wptr still advances; the CLR/WAIT states are skipped (WR_R→OUT).
  - out_left/out_right take the raw accepted samples; out_valid follows 3 cycles after the accept edge.
- Undefined: the port is absent and the filter always runs.

Decomposition:
- fir_sched_pkg holds:
  - the state enum (8 states, 3-bit encoding);
  - the ADDR_W and DATA_W defaults;
  - the CHAN_L=0 and CHAN_R=1 constants.
- No sub-module: the FSM, wptr and guard counter are small and stay inline.

Test Plan:
- Reset, then one pair (L=0x1000, R=0xF000) with a filter model returning 0x0123 then 0x0456.
  - Writes occur to addr 0 on chan 0 then chan 1.
  - fir_start_addr=1.
  - out_valid pulse with out_left=0x0123, out_right=0x0456.
- 128 consecutive pairs: wptr wraps 127→0; on the 128th pair fir_start_addr=0 and buf_wr_addr=127.
- fir_done held high from CLR_L onward: it is ignored for DONE_GUARD cycles, and the result is latched only on the 3rd WAIT_L cycle.
- sample_valid pulsed in WAIT_L: overrun=1, no extra writes, current out_valid is unaffected, overrun persists after subsequent pairs.
- Reset asserted in WAIT_R:
  - Immediately fir_reset=1 and busy=0, with no out_valid.
  - The next pair writes at addr 0.
- With FIR_SCHED_BYPASS_EN and bypass=1, pair (0x7FFF, 0x8000): out_valid arrives 3 cycles after accept with the raw values, and fir_reset stays 1 throughout.
